// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit.
// Multiply: shift-add, radix-2 (32 cycles) by default; radix-4 Booth (16 cycles)
// when MULTDIV_BOOTH_EN is defined. Divide: restoring division on magnitudes,
// one quotient bit per cycle (32 cycles), sign fixed up on the final cycle.
// A start pulse in any state aborts the current operation and restarts.
module multdiv_unit #(
  parameter int unsigned HOLD_RESULT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

`ifdef MULTDIV_BOOTH_EN
  localparam int unsigned MulShift = 2;
  localparam logic [4:0]  MulLast  = 5'd15;
`else
  localparam int unsigned MulShift = 1;
  localparam logic [4:0]  MulLast  = 5'd31;
`endif
  localparam logic [4:0]  DivLast  = 5'd31;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      r_state;
  logic [4:0]  r_cnt;
  // Multiply datapath
  logic [63:0] r_prod;
  logic [63:0] r_mcand;
  logic [32:0] r_mplier;
  // Divide datapath
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvsr;
  logic        r_neg;
  logic        r_dz;
  logic        r_ovf;
  // Registered outputs
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_rdy;

  logic [63:0] w_pp;
  logic [63:0] w_prod_nxt;
  logic        w_mul_exc;
  logic [32:0] w_rem_sh;
  logic        w_qbit;
  logic [31:0] w_rem_diff;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_q_mag;
  logic [31:0] w_div_res;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

  // Operand magnitudes for divide; 0x80000000 maps to itself as unsigned 2^31.
  assign w_a_mag = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign w_b_mag = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // Partial product selection for the current multiply step.
  always_comb begin
    w_pp = '0;
`ifdef MULTDIV_BOOTH_EN
    case (r_mplier[2:0])
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = r_mcand << 1;
      3'b100:         w_pp = 64'd0 - (r_mcand << 1);
      3'b101, 3'b110: w_pp = 64'd0 - r_mcand;
      default:        w_pp = '0;
    endcase
`else
    // Bit 31 of a two's-complement multiplier carries negative weight.
    if (r_mplier[0]) begin
      w_pp = (r_cnt == MulLast) ? (64'd0 - r_mcand) : r_mcand;
    end
`endif
    w_prod_nxt = r_prod + w_pp;
    w_mul_exc  = !((&w_prod_nxt[63:31]) || !(|w_prod_nxt[63:31]));
  end

  // One restoring-division step and the final signed quotient.
  always_comb begin
    w_rem_sh   = {r_rem, r_quo[31]};
    w_qbit     = (w_rem_sh >= {1'b0, r_dvsr});
    w_rem_diff = w_rem_sh[31:0] - r_dvsr;
    w_rem_nxt  = w_qbit ? w_rem_diff : w_rem_sh[31:0];
    w_q_mag    = {r_quo[30:0], w_qbit};
    w_div_res  = '0;
    if (!r_dz) begin
      w_div_res = r_neg ? (32'd0 - w_q_mag) : w_q_mag;
    end
  end

  // Control FSM, iteration registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if ((HOLD_RESULT == 0) && (r_state == StDone)) begin
        r_result <= '0;
        r_exc    <= 1'b0;
      end
      if (ctrl_MULT) begin
        r_state <= StMul;
        r_cnt   <= '0;
        r_prod  <= '0;
        r_mcand <= {{32{data_operandA[31]}}, data_operandA};
`ifdef MULTDIV_BOOTH_EN
        r_mplier <= {data_operandB, 1'b0};
`else
        r_mplier <= {1'b0, data_operandB};
`endif
      end else if (ctrl_DIV) begin
        r_state <= StDiv;
        r_cnt   <= '0;
        r_rem   <= '0;
        r_quo   <= w_a_mag;
        r_dvsr  <= w_b_mag;
        r_neg   <= data_operandA[31] ^ data_operandB[31];
        r_dz    <= (data_operandB == 32'd0);
        r_ovf   <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      end else begin
        case (r_state)
          StMul: begin
            r_prod   <= w_prod_nxt;
            r_mcand  <= r_mcand << MulShift;
            r_mplier <= r_mplier >> MulShift;
            r_cnt    <= r_cnt + 5'd1;
            if (r_cnt == MulLast) begin
              r_result <= w_prod_nxt[31:0];
              r_exc    <= w_mul_exc;
              r_rdy    <= 1'b1;
              r_state  <= StDone;
            end
          end
          StDiv: begin
            r_rem <= w_rem_nxt;
            r_quo <= w_q_mag;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == DivLast) begin
              r_result <= w_div_res;
              r_exc    <= r_dz | r_ovf;
              r_rdy    <= 1'b1;
              r_state  <= StDone;
            end
          end
          StDone:  r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit with a scoreboard of expected completions.
module tb_multdiv_unit;

`ifdef MULTDIV_BOOTH_EN
  localparam int MulLat = 16;
`else
  localparam int MulLat = 32;
`endif
  localparam int DivLat = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
    int          start;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_cnt = 0;
  int   rc;
  logic prev_rdy = 1'b0;

  multdiv_unit #(.HOLD_RESULT(1)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check any completion against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    if (data_resultRDY) begin
      rdy_cnt++;
      chk("rdy_single_cycle", {31'd0, prev_rdy}, 32'd0);
      chk("rdy_expected", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, "_result"}, data_result, e.res);
        chk({e.tag, "_exception"}, {31'd0, data_exception}, {31'd0, e.exc});
        chk({e.tag, "_latency"}, 32'(cyc - e.start - 1), 32'(e.lat));
      end
    end
    prev_rdy = data_resultRDY;
  endtask

  // Issue a start pulse; any earlier outstanding operation is aborted.
  task automatic start_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc, input string tag);
    exp_t e;
    sb.delete();
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = !mul;
    e.res   = res;
    e.exc   = exc;
    e.lat   = mul ? MulLat : DivLat;
    e.start = cyc;
    e.tag   = tag;
    sb.push_back(e);
    tick();
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    // Operand changes after the start edge must not matter.
    data_operandA = $urandom();
    data_operandB = $urandom();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    chk("completed_in_time", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);

    // First start on the first edge after release
    reset = 1'b1;
    start_op(1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7x-3");
    wait_done(60);
    tick();
    chk("hold_result", data_result, 32'hFFFF_FFEB);
    chk("rdy_dropped", {31'd0, data_resultRDY}, 32'd0);

    start_op(1'b0, 32'd100, 32'd7, 32'd14, 1'b0, "div_100/7");
    wait_done(60);
    start_op(1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_-7/2");
    wait_done(60);
    start_op(1'b0, 32'd5, 32'd0, 32'd0, 1'b1, "div_by_zero");
    wait_done(60);
    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
    wait_done(60);
    start_op(1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, "mul_ovf");
    wait_done(60);
    start_op(1'b1, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, "mul_max");
    wait_done(60);
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_x-1");
    wait_done(60);
    start_op(1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25, 1'b0, "mul_-5x-5");
    wait_done(60);

    // Abort: divide restarted by a multiply 10 cycles later
    start_op(1'b0, 32'd9, 32'd3, 32'd3, 1'b0, "div_aborted");
    repeat (9) tick();
    rc = rdy_cnt;
    start_op(1'b1, 32'd6, 32'd6, 32'd36, 1'b0, "mul_after_abort");
    wait_done(60);
    chk("single_rdy_after_abort", 32'(rdy_cnt - rc), 32'd1);

    // Reset 5 cycles into a multiply
    start_op(1'b1, 32'd3, 32'd4, 32'd12, 1'b0, "mul_reset");
    repeat (4) tick();
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_exception", {31'd0, data_exception}, 32'd0);
    chk("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    tick();
    // Start pulse while in reset must be ignored
    data_operandA = 32'd2;
    data_operandB = 32'd2;
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    reset = 1'b1;
    rc = rdy_cnt;
    repeat (40) tick();
    chk("no_rdy_after_reset", 32'(rdy_cnt - rc), 32'd0);

    // Brief reset, then start right at release
    reset = 1'b0;
    tick();
    reset = 1'b1;
    start_op(1'b0, 32'hFFFF_FF9C, 32'd10, 32'hFFFF_FFF6, 1'b0, "div_after_reset");
    wait_done(60);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
